// File: rtl/adf4158_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : adf4158_pkg                                                 |
// | Purpose  : Shared types and constants for the ADF4158 configuration    |
// |            controller: FSM state encodings, word geometry and the      |
// |            default register words.                                     |
// | Ports    : none (package)                                              |
// | Options  : ADF4158_LOCK_WAIT_EN (used by adf4158_ctrl)                 |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package adf4158_pkg;

  localparam int WORD_COUNT = 10;
  localparam int WORD_WIDTH = 32;

  localparam logic [31:0] DEF_R7_WORD  = 32'h0000_0007;
  localparam logic [31:0] DEF_R6A_WORD = 32'h0000_0006;
  localparam logic [31:0] DEF_R6B_WORD = 32'h0080_0006;
  localparam logic [31:0] DEF_R5A_WORD = 32'h0000_0005;
  localparam logic [31:0] DEF_R5B_WORD = 32'h0080_0005;
  localparam logic [31:0] DEF_R4_WORD  = 32'h0018_0104;
  localparam logic [31:0] DEF_R3_WORD  = 32'h0000_0043;
  localparam logic [31:0] DEF_R2_WORD  = 32'h0040_8002;
  localparam logic [31:0] DEF_R1_WORD  = 32'h0000_0001;
  localparam logic [31:0] DEF_R0_WORD  = 32'h8000_0000;

  // Top-level sequencer. ST_SEND covers the SHIFT/LATCH/GAP phases, which
  // are tracked inside the word serializer.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PWRUP = 3'd1,
    ST_SEND  = 3'd2,
    ST_LOCK  = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

  // Per-word serializer phase.
  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_SHIFT = 2'd1,
    PH_LATCH = 2'd2,
    PH_GAP   = 2'd3
  } word_phase_t;

endpackage
`default_nettype wire

// File: rtl/adf4158_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : adf4158_if                                                  |
// | Purpose  : Pin bundle between the controller and the ADF4158.          |
// | Ports    : ce, le, sclk, data, txdata (controller -> synthesizer)      |
// |            muxout                   (synthesizer -> controller)        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface adf4158_if;
  logic ce;
  logic le;
  logic sclk;
  logic data;
  logic txdata;
  logic muxout;

  modport master (output ce, le, sclk, data, txdata, input muxout);
  modport slave  (input ce, le, sclk, data, txdata, output muxout);
endinterface
`default_nettype wire

// File: rtl/adf4158_spi_word.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : adf4158_spi_word                                            |
// | Purpose  : Serializes one 32-bit word MSB first (CLK_DIV clocks per    |
// |            bit, sclk low then high), then one CLK_DIV-long le pulse    |
// |            and a CLK_DIV-long quiet gap.                               |
// | Ports    : clk, rst_n   clock, async active-low reset                  |
// |            abort        synchronous clear, dominates start             |
// |            start, word  load a word and begin shifting                 |
// |            sclk/le/data registered serial outputs                      |
// |            word_done    high in the last gap cycle (combinational)     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module adf4158_spi_word
  import adf4158_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] word,
  output logic        sclk,
  output logic        le,
  output logic        data,
  output logic        word_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  word_phase_t       r_phase, w_phase_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [4:0]        r_bit, w_bit_d;
  logic [31:0]       r_sr, w_sr_d;
  logic              w_sclk_d, w_le_d, w_data_d;

  // word_done lines up with the edge that would otherwise idle the block,
  // so a start on that same edge chains words with no dead cycle.
  assign word_done = (r_phase == PH_GAP) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sr    <= '0;
      sclk    <= 1'b0;
      le      <= 1'b0;
      data    <= 1'b0;
    end else begin
      r_phase <= w_phase_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_sr    <= w_sr_d;
      sclk    <= w_sclk_d;
      le      <= w_le_d;
      data    <= w_data_d;
    end
  end

  always_comb begin
    w_phase_d = r_phase;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_sr_d    = r_sr;
    w_sclk_d  = sclk;
    w_le_d    = le;
    w_data_d  = data;
    if (abort) begin
      w_phase_d = PH_IDLE;
      w_cnt_d   = '0;
      w_bit_d   = '0;
      w_sr_d    = '0;
      w_sclk_d  = 1'b0;
      w_le_d    = 1'b0;
      w_data_d  = 1'b0;
    end else if (start) begin
      w_phase_d = PH_SHIFT;
      w_cnt_d   = '0;
      w_bit_d   = 5'd31;
      w_sr_d    = word;
      w_sclk_d  = 1'b0;
      w_le_d    = 1'b0;
      w_data_d  = word[31];
    end else begin
      case (r_phase)
        PH_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_d  = '0;
            w_sclk_d = 1'b0;
            if (r_bit == 5'd0) begin
              w_phase_d = PH_LATCH;
              w_le_d    = 1'b1;
              w_data_d  = 1'b0;
            end else begin
              w_bit_d  = r_bit - 5'd1;
              w_sr_d   = {r_sr[30:0], 1'b0};
              w_data_d = r_sr[30];
            end
          end else begin
            w_cnt_d  = r_cnt + 1'b1;
            // second half of the bit period drives sclk high
            w_sclk_d = (32'(r_cnt) + 32'd1 >= 32'(CLK_DIV / 2));
          end
        end
        PH_LATCH: begin
          if (r_cnt == CNT_LAST) begin
            w_phase_d = PH_GAP;
            w_cnt_d   = '0;
            w_le_d    = 1'b0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        PH_GAP: begin
          if (r_cnt == CNT_LAST) begin
            w_phase_d = PH_IDLE;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        default: begin
          w_sclk_d = 1'b0;
          w_le_d   = 1'b0;
          w_data_d = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adf4158_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : adf4158_ctrl                                                |
// | Purpose  : Power-up and serial configuration of the ADF4158. Raises    |
// |            ce on enable, waits CE_WAIT clocks, shifts R7..R0 (ten      |
// |            words) and then holds config_done high.                     |
// | Ports    : clk, rst_n   clock, async active-low reset                  |
// |            enable       level; low anywhere aborts back to idle        |
// |            config_done  registered; release for downstream logic       |
// |            bus          adf4158_if.master pin bundle                   |
// | Options  : ADF4158_LOCK_WAIT_EN  wait for LOCK_CYCLES consecutive      |
// |            synchronized-high muxout samples before config_done         |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module adf4158_ctrl
  import adf4158_pkg::*;
#(
  parameter int          CLK_DIV     = 2,
  parameter int          CE_WAIT     = 1000,
  parameter logic [31:0] R7_WORD     = DEF_R7_WORD,
  parameter logic [31:0] R6A_WORD    = DEF_R6A_WORD,
  parameter logic [31:0] R6B_WORD    = DEF_R6B_WORD,
  parameter logic [31:0] R5A_WORD    = DEF_R5A_WORD,
  parameter logic [31:0] R5B_WORD    = DEF_R5B_WORD,
  parameter logic [31:0] R4_WORD     = DEF_R4_WORD,
  parameter logic [31:0] R3_WORD     = DEF_R3_WORD,
  parameter logic [31:0] R2_WORD     = DEF_R2_WORD,
  parameter logic [31:0] R1_WORD     = DEF_R1_WORD,
  parameter logic [31:0] R0_WORD     = DEF_R0_WORD,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        config_done,
  adf4158_if.master   bus
);

  localparam int WAIT_W = $clog2(CE_WAIT + 1);
  localparam logic [3:0] LAST_IDX = 4'(WORD_COUNT - 1);

  ctrl_state_t       r_state, w_state_d;
  logic [WAIT_W-1:0] r_wait, w_wait_d;
  logic [3:0]        r_idx, w_idx_d, w_start_idx;
  logic              r_ce, w_ce_d, w_done_d;
  logic              w_start, w_word_done;
  logic [31:0]       w_start_word;

`ifdef ADF4158_LOCK_WAIT_EN
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  logic [1:0]        r_mux_sync;
  logic [LOCK_W-1:0] r_lock_cnt, w_lock_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_sync <= 2'b00;
      r_lock_cnt <= '0;
    end else begin
      r_mux_sync <= {r_mux_sync[0], bus.muxout};
      r_lock_cnt <= w_lock_cnt_d;
    end
  end
`endif

  assign bus.ce     = r_ce;
  assign bus.txdata = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_idx       <= '0;
      r_ce        <= 1'b0;
      config_done <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_wait      <= w_wait_d;
      r_idx       <= w_idx_d;
      r_ce        <= w_ce_d;
      config_done <= w_done_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_wait_d    = r_wait;
    w_idx_d     = r_idx;
    w_ce_d      = r_ce;
    w_done_d    = config_done;
    w_start     = 1'b0;
    w_start_idx = 4'd0;
`ifdef ADF4158_LOCK_WAIT_EN
    w_lock_cnt_d = r_lock_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        w_ce_d   = 1'b0;
        w_done_d = 1'b0;
        if (enable) begin
          w_state_d = ST_PWRUP;
          w_ce_d    = 1'b1;
          w_wait_d  = WAIT_W'(CE_WAIT - 1);
        end
      end
      ST_PWRUP: begin
        if (r_wait == '0) begin
          w_state_d   = ST_SEND;
          w_idx_d     = 4'd0;
          w_start     = 1'b1;
          w_start_idx = 4'd0;
        end else begin
          w_wait_d = r_wait - 1'b1;
        end
      end
      ST_SEND: begin
        if (w_word_done) begin
          if (r_idx == LAST_IDX) begin
`ifdef ADF4158_LOCK_WAIT_EN
            w_state_d    = ST_LOCK;
            w_lock_cnt_d = '0;
`else
            w_state_d = ST_DONE;
            w_done_d  = 1'b1;
`endif
          end else begin
            w_idx_d     = r_idx + 4'd1;
            w_start     = 1'b1;
            w_start_idx = r_idx + 4'd1;
          end
        end
      end
`ifdef ADF4158_LOCK_WAIT_EN
      ST_LOCK: begin
        if (r_mux_sync[1]) begin
          if (r_lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
            w_state_d = ST_DONE;
            w_done_d  = 1'b1;
          end else begin
            w_lock_cnt_d = r_lock_cnt + 1'b1;
          end
        end else begin
          w_lock_cnt_d = '0;
        end
      end
`endif
      ST_DONE: begin
        w_ce_d   = 1'b1;
        w_done_d = 1'b1;
      end
      default: w_state_d = ST_IDLE;
    endcase

    // Dropping enable outside IDLE abandons the sequence entirely.
    if (!enable && r_state != ST_IDLE) begin
      w_state_d = ST_IDLE;
      w_wait_d  = '0;
      w_idx_d   = '0;
      w_ce_d    = 1'b0;
      w_done_d  = 1'b0;
      w_start   = 1'b0;
`ifdef ADF4158_LOCK_WAIT_EN
      w_lock_cnt_d = '0;
`endif
    end
  end

  always_comb begin
    case (w_start_idx)
      4'd0:    w_start_word = R7_WORD;
      4'd1:    w_start_word = R6A_WORD;
      4'd2:    w_start_word = R6B_WORD;
      4'd3:    w_start_word = R5A_WORD;
      4'd4:    w_start_word = R5B_WORD;
      4'd5:    w_start_word = R4_WORD;
      4'd6:    w_start_word = R3_WORD;
      4'd7:    w_start_word = R2_WORD;
      4'd8:    w_start_word = R1_WORD;
      default: w_start_word = R0_WORD;
    endcase
  end

  adf4158_spi_word #(
    .CLK_DIV (CLK_DIV)
  ) u_spi_word (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (~enable),
    .start     (w_start),
    .word      (w_start_word),
    .sclk      (bus.sclk),
    .le        (bus.le),
    .data      (bus.data),
    .word_done (w_word_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_adf4158_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_adf4158_ctrl                                             |
// | Purpose  : Self-checking bench for adf4158_ctrl. A default instance    |
// |            (CLK_DIV=2, CE_WAIT=1000) is checked against a table of     |
// |            timed output vectors and the captured register words; a     |
// |            second instance (CLK_DIV=4, CE_WAIT=20) shares the stimulus |
// |            and is protocol-checked every cycle.                        |
// | Options  : ADF4158_LOCK_WAIT_EN adds the muxout lock sequence          |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_adf4158_ctrl;
  localparam int LOCK_CYCLES = 16;
`ifdef ADF4158_LOCK_WAIT_EN
  localparam logic END_DONE = 1'b0;
`else
  localparam logic END_DONE = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic muxout = 1'b0;
  logic done, done4;

  adf4158_if bus ();
  adf4158_if bus4 ();
  assign bus.muxout  = muxout;
  assign bus4.muxout = muxout;

  adf4158_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .config_done(done), .bus(bus)
  );
  adf4158_ctrl #(.CLK_DIV(4), .CE_WAIT(20)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .config_done(done4), .bus(bus4)
  );

  always #12.5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int   off;
    logic ce;
    logic sclk;
    logic le;
    logic data;
    logic done;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  addr;
  } wexp_t;

  vec_t  vecs[14];
  wexp_t wexp[10];

  // Serial capture on the device side: shift on sclk rise, latch on le rise.
  logic [31:0] cap = '0, cap4 = '0;
  logic [31:0] got[$], got4[$];
  int n_rise = 0, n_rise4 = 0, n_le_cyc = 0, n_le_cyc4 = 0;

  always @(posedge bus.sclk)  begin cap  = {cap[30:0],  bus.data};  n_rise++;  end
  always @(posedge bus4.sclk) begin cap4 = {cap4[30:0], bus4.data}; n_rise4++; end
  always @(posedge bus.le)  got.push_back(cap);
  always @(posedge bus4.le) got4.push_back(cap4);

  logic prev_sclk = 1'b0, prev_data = 1'b0, prev_sclk4 = 1'b0, prev_data4 = 1'b0;
  always @(negedge clk) begin
    if (bus.le)  n_le_cyc++;
    if (bus4.le) n_le_cyc4++;
    if (rst_n) begin
      check("le_sclk_overlap",  32'(bus.le & bus.sclk), 32'd0);
      check("le_sclk_overlap4", 32'(bus4.le & bus4.sclk), 32'd0);
      check("txdata",  32'(bus.txdata), 32'd0);
      check("txdata4", 32'(bus4.txdata), 32'd0);
      if (prev_sclk && bus.sclk)   check("data_stable",  32'(bus.data),  32'(prev_data));
      if (prev_sclk4 && bus4.sclk) check("data_stable4", 32'(bus4.data), 32'(prev_data4));
    end
    prev_sclk  = bus.sclk;  prev_data  = bus.data;
    prev_sclk4 = bus4.sclk; prev_data4 = bus4.data;
  end

  task automatic clear_capture();
    got.delete(); got4.delete();
    n_rise = 0; n_rise4 = 0; n_le_cyc = 0; n_le_cyc4 = 0;
  endtask

  // Full configuration from IDLE. Offsets count posedges from the edge that
  // samples enable high (offset 0), sampled 1 time unit after that edge.
  task automatic run_full(input string tag);
    int now;
    muxout = 1'b0;
    clear_capture();
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    now = 0;
    for (int i = 0; i < 14; i++) begin
      repeat (vecs[i].off - now) @(posedge clk);
      if (vecs[i].off != now) #1;
      now = vecs[i].off;
      check($sformatf("%s_vec%0d_t%0d", tag, i, vecs[i].off),
            {27'd0, bus.ce, bus.sclk, bus.le, bus.data, done},
            {27'd0, vecs[i].ce, vecs[i].sclk, vecs[i].le, vecs[i].data, vecs[i].done});
    end
`ifdef ADF4158_LOCK_WAIT_EN
    for (int i = 0; i < 6; i++) begin
      muxout = ~muxout;
      @(posedge clk); #1;
    end
    muxout = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    muxout = 1'b1;
    repeat (LOCK_CYCLES + 1) @(posedge clk);
    #1;
    check($sformatf("%s_lock_early", tag), 32'(done), 32'd0);
    @(posedge clk); #1;
    check($sformatf("%s_lock_done", tag), 32'(done), 32'd1);
`endif
    check($sformatf("%s_sclk_rises", tag),  32'(n_rise),     32'd320);
    check($sformatf("%s_le_pulses", tag),   32'(got.size()), 32'd10);
    check($sformatf("%s_le_cycles", tag),   32'(n_le_cyc),   32'd20);
    check($sformatf("%s_sclk_rises4", tag), 32'(n_rise4),    32'd320);
    check($sformatf("%s_le_cycles4", tag),  32'(n_le_cyc4),  32'd40);
    check($sformatf("%s_le_pulses4", tag),  32'(got4.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < got.size()) begin
        check($sformatf("%s_word%0d", tag, i), got[i], wexp[i].word);
        check($sformatf("%s_addr%0d", tag, i), 32'(got[i][2:0]), 32'(wexp[i].addr));
      end
      if (i < got4.size())
        check($sformatf("%s_word4_%0d", tag, i), got4[i], wexp[i].word);
    end
  endtask

  initial begin
    wexp[0] = '{32'h0000_0007, 3'd7};
    wexp[1] = '{32'h0000_0006, 3'd6};
    wexp[2] = '{32'h0080_0006, 3'd6};
    wexp[3] = '{32'h0000_0005, 3'd5};
    wexp[4] = '{32'h0080_0005, 3'd5};
    wexp[5] = '{32'h0018_0104, 3'd4};
    wexp[6] = '{32'h0000_0043, 3'd3};
    wexp[7] = '{32'h0040_8002, 3'd2};
    wexp[8] = '{32'h0000_0001, 3'd1};
    wexp[9] = '{32'h8000_0000, 3'd0};

    //          off   ce    sclk  le    data  done
    vecs[0]  = '{0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // ce up, powering
    vecs[1]  = '{999,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // last wait cycle
    vecs[2]  = '{1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // R7 bit31 low half
    vecs[3]  = '{1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // first sclk rise
    vecs[4]  = '{1064, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // R7 le pulse
    vecs[5]  = '{1065, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1066, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // gap
    vecs[7]  = '{1068, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // R6A bit31
    vecs[8]  = '{1152, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // R6B bit23 = 1
    vecs[9]  = '{1153, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1612, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // R0 bit31 = 1
    vecs[11] = '{1679, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // last gap cycle
    vecs[12] = '{1680, 1'b1, 1'b0, 1'b0, 1'b0, END_DONE};
    vecs[13] = '{1700, 1'b1, 1'b0, 1'b0, 1'b0, END_DONE};

    // Reset and idle with enable low.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("idle_outputs",
            {26'd0, bus.ce, bus.le, bus.sclk, bus.data, bus.txdata, done}, 32'd0);
    end

    run_full("run1");

    // Abort during word 4 (word 4 spans offsets 1272..1339).
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clear_capture();
    enable = 1'b1;
    repeat (1 + 1292) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk); #1;
    check("abort_outputs", {27'd0, bus.ce, bus.le, bus.sclk, bus.data, done}, 32'd0);
    check("abort_words_latched", 32'(got.size()), 32'd4);
    begin
      int rises_at_abort;
      rises_at_abort = n_rise;
      repeat (60) @(posedge clk);
      #1;
      check("abort_no_sclk", 32'(n_rise), 32'(rises_at_abort));
      check("abort_ce_low", 32'(bus.ce), 32'd0);
    end

    run_full("run2");

    // Asynchronous reset while configured.
    rst_n = 1'b0;
    #1;
    check("async_reset", {26'd0, bus.ce, bus.le, bus.sclk, bus.data, bus.txdata, done}, 32'd0);
    enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_idle", {27'd0, bus.ce, bus.le, bus.sclk, done, done4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
